// File: rtl/mxrv_inst_rom_resp_pkg.sv
// rtl/mxrv_inst_rom_resp_pkg.sv - shared constants, stage type and address check for the instruction ROM responder
package mxrv_inst_rom_resp_pkg;

    localparam int          PORT_WORD_WIDTH = 32;
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
    localparam logic [31:0] INST_NOP        = 32'h0000_0013;
    localparam logic        ENABLE          = 1'b1;
    localparam logic        DISABLE         = 1'b0;
    localparam logic        RST_ENABLE      = 1'b1;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } stage_t;

    localparam stage_t STAGE_RESET = '{valid: DISABLE, err: DISABLE, data: ZERO_WORD};

    // Misaligned or beyond the array: no modulo aliasing of high addresses.
    function automatic logic pc_fault(input logic [31:0] pc, input logic [31:0] depth);
        return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/mxrv_inst_rom_resp_if.sv
// rtl/mxrv_inst_rom_resp_if.sv - fetch request/response, flush and program-port bundle
interface mxrv_inst_rom_resp_if #(
    parameter int AW = 10
);
    logic          rd_valid_i;
    logic          rd_ready_o;
    logic [31:0]   pc_i;
    logic          inst_valid_o;
    logic [31:0]   inst_data_o;
    logic          inst_err_o;
    logic          flush_i;
    logic          wr_en_i;
    logic [AW-1:0] wr_addr_i;
    logic [31:0]   wr_data_i;

    modport master (
        output rd_valid_i, pc_i, flush_i, wr_en_i, wr_addr_i, wr_data_i,
        input  rd_ready_o, inst_valid_o, inst_data_o, inst_err_o
    );

    modport slave (
        input  rd_valid_i, pc_i, flush_i, wr_en_i, wr_addr_i, wr_data_i,
        output rd_ready_o, inst_valid_o, inst_data_o, inst_err_o
    );
endinterface

// File: rtl/mxrv_rom_array.sv
// rtl/mxrv_rom_array.sv - single-clock instruction array, synchronous read-before-write, no reset
module mxrv_rom_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Kept free of reset and muxing so the storage maps onto block RAM.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mxrv_inst_rom_resp.sv
// rtl/mxrv_inst_rom_resp.sv - fetch responder: fixed-latency instruction reads with flush and boot programming
module mxrv_inst_rom_resp #(
    parameter int DEPTH   = 1024,
    parameter int AW      = 10,
    parameter int LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    mxrv_inst_rom_resp_if.slave         bus
);
    import mxrv_inst_rom_resp_pkg::*;

    logic        ready_q,  ready_d;
    logic        s0_valid_q, s0_valid_d;
    logic        s0_err_q,   s0_err_d;
    logic        s0_loaded_q, s0_loaded_d;
    logic        rd_ready;
    logic        accept;
    logic        req_err;
    logic [31:0] ram_rdata;
    logic [31:0] s0_data;
    stage_t      out_stage;

    always_comb begin
        rd_ready    = ready_q & ~bus.flush_i;
        accept      = bus.rd_valid_i & rd_ready;
        req_err     = pc_fault(bus.pc_i, 32'(DEPTH));
        ready_d     = ENABLE;
        s0_valid_d  = accept;
        s0_err_d    = accept ? req_err : s0_err_q;
        s0_loaded_d = s0_loaded_q | accept;
        // Until the first acceptance the array output is meaningless, so show the reset word.
        if (!s0_loaded_q) begin
            s0_data = ZERO_WORD;
        end else if (s0_err_q) begin
            s0_data = INST_NOP;
        end else begin
            s0_data = ram_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            ready_q     <= DISABLE;
            s0_valid_q  <= DISABLE;
            s0_err_q    <= DISABLE;
            s0_loaded_q <= DISABLE;
        end else begin
            ready_q     <= ready_d;
            s0_valid_q  <= s0_valid_d;
            s0_err_q    <= s0_err_d;
            s0_loaded_q <= s0_loaded_d;
        end
    end

    mxrv_rom_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .re    (accept & ~req_err),
        .raddr (bus.pc_i[AW+1:2]),
        .rdata (ram_rdata),
        .we    (bus.wr_en_i),
        .waddr (bus.wr_addr_i),
        .wdata (bus.wr_data_i)
    );

    if (LATENCY == 1) begin : g_direct
        assign out_stage = '{valid: s0_valid_q, err: s0_err_q, data: s0_data};
    end else begin : g_pipe
        localparam int NS = LATENCY - 1;

        stage_t pipe_q [NS];
        stage_t pipe_d [NS];
        stage_t src    [NS];

        // Valid moves every cycle; payload only moves with a live, unflushed response so outputs hold.
        always_comb begin
            src[0] = '{valid: s0_valid_q, err: s0_err_q, data: s0_data};
            for (int i = 1; i < NS; i++) begin
                src[i] = pipe_q[i-1];
            end
            for (int i = 0; i < NS; i++) begin
                pipe_d[i]       = pipe_q[i];
                pipe_d[i].valid = src[i].valid & ~bus.flush_i;
                if (src[i].valid && !bus.flush_i) begin
                    pipe_d[i].err  = src[i].err;
                    pipe_d[i].data = src[i].data;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst == RST_ENABLE) begin
                for (int i = 0; i < NS; i++) begin
                    pipe_q[i] <= STAGE_RESET;
                end
            end else begin
                for (int i = 0; i < NS; i++) begin
                    pipe_q[i] <= pipe_d[i];
                end
            end
        end

        assign out_stage = pipe_q[NS-1];
    end

    assign bus.rd_ready_o   = rd_ready;
    assign bus.inst_valid_o = out_stage.valid;
    assign bus.inst_err_o   = out_stage.err;
    assign bus.inst_data_o  = out_stage.data;

endmodule

// File: tb/tb_mxrv_inst_rom_resp.sv
// tb/tb_mxrv_inst_rom_resp.sv - three latency variants driven in lockstep against a queue-based response model
module tb_mxrv_inst_rom_resp;
    import mxrv_inst_rom_resp_pkg::*;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int NL    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mxrv_inst_rom_resp_if #(.AW(AW)) bus1 ();
    mxrv_inst_rom_resp_if #(.AW(AW)) bus2 ();
    mxrv_inst_rom_resp_if #(.AW(AW)) bus3 ();

    mxrv_inst_rom_resp #(.DEPTH(DEPTH), .AW(AW), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(bus1));
    mxrv_inst_rom_resp #(.DEPTH(DEPTH), .AW(AW), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(bus2));
    mxrv_inst_rom_resp #(.DEPTH(DEPTH), .AW(AW), .LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .bus(bus3));

    logic        obs_ready [NL];
    logic        obs_valid [NL];
    logic        obs_err   [NL];
    logic [31:0] obs_data  [NL];

    assign obs_ready[0] = bus1.rd_ready_o;  assign obs_valid[0] = bus1.inst_valid_o;
    assign obs_ready[1] = bus2.rd_ready_o;  assign obs_valid[1] = bus2.inst_valid_o;
    assign obs_ready[2] = bus3.rd_ready_o;  assign obs_valid[2] = bus3.inst_valid_o;
    assign obs_err[0]   = bus1.inst_err_o;  assign obs_data[0]  = bus1.inst_data_o;
    assign obs_err[1]   = bus2.inst_err_o;  assign obs_data[1]  = bus2.inst_data_o;
    assign obs_err[2]   = bus3.inst_err_o;  assign obs_data[2]  = bus3.inst_data_o;

    // Current stimulus, mirrored into all three interfaces
    logic          cur_v, cur_fl, cur_we;
    logic [31:0]   cur_pc, cur_wd;
    logic [AW-1:0] cur_wa;

    // Reference model: a response is due LATENCY-1 edges after acceptance (lane k has LATENCY k+1)
    typedef struct {
        int          due;
        int          lane;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        pend [$];
    logic [31:0] mem_m [DEPTH];
    logic        mrdy;
    logic        exp_v  [NL];
    logic [31:0] last_d [NL];
    logic        last_e [NL];
    int          cyc;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic fl,
                          input logic we, input logic [AW-1:0] wa, input logic [31:0] wd);
        cur_v = v; cur_pc = pc; cur_fl = fl; cur_we = we; cur_wa = wa; cur_wd = wd;
        bus1.rd_valid_i = v; bus1.pc_i = pc; bus1.flush_i = fl; bus1.wr_en_i = we; bus1.wr_addr_i = wa; bus1.wr_data_i = wd;
        bus2.rd_valid_i = v; bus2.pc_i = pc; bus2.flush_i = fl; bus2.wr_en_i = we; bus2.wr_addr_i = wa; bus2.wr_data_i = wd;
        bus3.rd_valid_i = v; bus3.pc_i = pc; bus3.flush_i = fl; bus3.wr_en_i = we; bus3.wr_addr_i = wa; bus3.wr_data_i = wd;
    endtask

    task automatic model_edge();
        logic        acc, e;
        logic [31:0] d;
        if (rst) begin
            pend.delete();
            mrdy = 1'b0;
            for (int k = 0; k < NL; k++) begin
                exp_v[k] = 1'b0; last_d[k] = 32'h0; last_e[k] = 1'b0;
            end
        end else begin
            acc = cur_v && mrdy && !cur_fl;
            if (cur_fl) pend.delete();
            if (acc) begin
                e = (cur_pc % 4 != 0) || (cur_pc >= DEPTH * 4);
                if (e) d = 32'h0000_0013;
                else   d = mem_m[cur_pc / 4];
                for (int k = 0; k < NL; k++) pend.push_back('{due: cyc + k, lane: k, data: d, err: e});
            end
            for (int k = 0; k < NL; k++) exp_v[k] = 1'b0;
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due == cyc) begin
                    exp_v[pend[i].lane]  = 1'b1;
                    last_d[pend[i].lane] = pend[i].data;
                    last_e[pend[i].lane] = pend[i].err;
                    pend.delete(i);
                end
            end
            mrdy = 1'b1;
        end
        if (cur_we) mem_m[cur_wa] = cur_wd;
    endtask

    task automatic check_all();
        for (int k = 0; k < NL; k++) begin
            chk($sformatf("L%0d ready", k + 1), 32'(obs_ready[k]), 32'(mrdy && !cur_fl));
            chk($sformatf("L%0d valid", k + 1), 32'(obs_valid[k]), 32'(exp_v[k]));
            chk($sformatf("L%0d data", k + 1),  obs_data[k], last_d[k]);
            chk($sformatf("L%0d err", k + 1),   32'(obs_err[k]), 32'(last_e[k]));
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [31:0] prog [4];
    logic [31:0] rpc;
    int          kind;

    initial begin
        prog[0] = 32'h0050_0093; prog[1] = 32'h0010_0113;
        prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_006F;
        cyc = 0;
        mrdy = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
        for (int k = 0; k < NL; k++) begin exp_v[k] = 1'b0; last_d[k] = 32'h0; last_e[k] = 1'b0; end

        // Reset and release
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("ready right after release", 32'(obs_ready[0]), 32'h0);

        // Boot-image programming of words 0..63
        for (int i = 0; i < 64; i++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b1, AW'(i), (i < 4) ? prog[i] : $urandom);
            cycle();
            if (i == 0) chk("ready one edge after release", 32'(obs_ready[0]), 32'h1);
        end

        // Back-to-back fetches at LATENCY=1
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(i * 4), 1'b0, 1'b0, '0, 32'h0);
            cycle();
            chk("b2b L1 valid", 32'(obs_valid[0]), 32'h1);
            chk("b2b L1 word", obs_data[0], prog[i]);
        end
        idle(4);

        // Single request at LATENCY=3
        set_in(1'b1, 32'h4, 1'b0, 1'b0, '0, 32'h0);
        cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
        cycle();
        chk("L3 not yet valid", 32'(obs_valid[2]), 32'h0);
        cycle();
        chk("L3 valid at N+2", 32'(obs_valid[2]), 32'h1);
        chk("L3 word", obs_data[2], 32'h0010_0113);
        cycle();
        chk("L3 pulse width", 32'(obs_valid[2]), 32'h0);

        // Error responses
        set_in(1'b1, 32'h6, 1'b0, 1'b0, '0, 32'h0);
        cycle();
        chk("misaligned err", 32'(obs_err[0]), 32'h1);
        chk("misaligned nop", obs_data[0], 32'h0000_0013);
        set_in(1'b1, 32'h1000, 1'b0, 1'b0, '0, 32'h0);
        cycle();
        chk("out-of-range err", 32'(obs_err[0]), 32'h1);
        chk("out-of-range nop", obs_data[0], 32'h0000_0013);
        idle(4);

        // Flush drops in-flight responses
        set_in(1'b1, 32'h0, 1'b0, 1'b0, '0, 32'h0);
        cycle();
        set_in(1'b1, 32'h4, 1'b0, 1'b0, '0, 32'h0);
        cycle();
        set_in(1'b1, 32'h8, 1'b1, 1'b0, '0, 32'h0);
        #1;
        chk("ready low during flush", 32'(obs_ready[2]), 32'h0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
            cycle();
            chk("L3 no pulse after flush", 32'(obs_valid[2]), 32'h0);
        end
        set_in(1'b1, 32'h8, 1'b0, 1'b0, '0, 32'h0);
        cycle();
        idle(2);
        chk("L3 post-flush word", obs_data[2], 32'h0020_81B3);
        idle(2);

        // Same-edge read and write of one index
        set_in(1'b1, 32'h8, 1'b0, 1'b1, AW'(2), 32'hDEAD_BEEF);
        cycle();
        chk("read-before-write old", obs_data[0], 32'h0020_81B3);
        set_in(1'b1, 32'h8, 1'b0, 1'b0, '0, 32'h0);
        cycle();
        chk("read after write new", obs_data[0], 32'hDEAD_BEEF);
        idle(4);

        // Reset while a LATENCY=2 response is in flight
        set_in(1'b1, 32'hC, 1'b0, 1'b0, '0, 32'h0);
        cycle();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
        rst = 1'b1;
        #1;
        chk("async reset clears L2 data", obs_data[1], 32'h0);
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("L2 no pulse after reset", 32'(obs_valid[1]), 32'h0);
        end

        // Random traffic over the programmed window plus fault addresses
        for (int i = 0; i < 500; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 8)       rpc = 32'($urandom_range(0, 63)) * 4;
            else if (kind == 8) rpc = (32'($urandom_range(0, 63)) * 4) | 32'($urandom_range(1, 3));
            else                rpc = 32'h1000 + ($urandom & 32'h7FFF_FFFC);
            set_in($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 4) == 0, AW'($urandom_range(0, 63)), $urandom);
            cycle();
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mxrv_inst_rom_resp.md
Name: mxrv_inst_rom_resp

Overview:
- Instruction-memory responder on the fetch read channel.
- Accepts a PC address via a valid/ready request handshake.
- Reads a word-addressed instruction array.
- Returns the instruction with a one-cycle valid pulse after a fixed, parameterised latency.
- Also provides a load/write port for boot-image programming, and a flush input that discards in-flight responses on jump/redirect.

Parameters:
- DEPTH, 1024: number of 32-bit instruction words; power of two.
- AW, 10: word-index width, log2(DEPTH).
- LATENCY, 1: cycles from request acceptance to inst_valid_o; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_valid_i  in  1  fetch request valid.
- rd_ready_o  out  1  responder can accept a request this cycle.
- pc_i  in  32  byte address of requested instruction.
- inst_valid_o  out  1  one-cycle pulse; response valid.
- inst_data_o  out  32  instruction word (`PORT_WORD_WIDTH).
- inst_err_o  out  1  response is an error (misaligned or out of range); qualified by inst_valid_o.
- flush_i  in  1  drop all in-flight responses.
- wr_en_i  in  1  program-port write strobe.
- wr_addr_i  in  AW  program-port word index.
- wr_data_i  in  32  program-port write data.

Behaviour:
- Reset (rst=1, asynchronous):
  - rd_ready_o=0, inst_valid_o=0, inst_data_o=`ZeroWord, inst_err_o=0.
  - All pipeline stage valids cleared.
  - Array contents undefined; no clear.
- ready_q register: 0 in reset; set to 1 at the first rising edge with rst=0.
- rd_ready_o = ready_q & ~flush_i. No other backpressure; the consumer always sinks responses.
- Request accepted when rd_valid_i & rd_ready_o at a rising edge.
- Stage 0 captures:
  - valid=1;
  - err = (pc_i[1:0]!=0) | (pc_i[31:2] >= DEPTH);
  - index = pc_i[AW+1:2].
- Array read is synchronous; data registered at stage 0.
- Stages 1..LATENCY-1 shift valid/data/err each cycle.
- Output registers are the last stage:
  - A request accepted at edge N gives inst_valid_o=1 from edge N+LATENCY-1 for exactly one cycle.
  - For LATENCY=1, the response is visible in the cycle after acceptance.
- Back-to-back requests every cycle give back-to-back responses; throughput is 1 per cycle; order is preserved.
- Error response: inst_err_o=1 and inst_data_o=`INST_NOP (32'h0000_0013); the array is not read.
- No request accepted in a cycle: the stage-0 valid is cleared.
  - inst_valid_o=0 when no valid response is present.
  - inst_data_o and inst_err_o hold their last values.
- flush_i=1 at an edge:
  - Every stage valid and inst_valid_o clear at that edge.
  - No request is accepted (ready low).
  - inst_data_o is held.
  - A response scheduled to appear at that edge is suppressed.
- Write port: wr_en_i=1 writes wr_data_i to mem[wr_addr_i] at the edge.
- Read and write to the same index at the same edge: read returns OLD data (read-before-write).
- rst asserted mid-operation: all in-flight responses are lost and no inst_valid_o pulse follows. After release, ready returns one edge later.
- pc_i wrap: addresses at or above DEPTH*4 are errors. No aliasing or modulo.

Decomposition:
- Shared package/defines:
  - `PORT_WORD_WIDTH (31:0), `ZeroWord, `Enable/`Disable, `RstEnable redefined for active-high as 1'b1.
  - New `INST_NOP 32'h0000_0013.
- Sub-module mxrv_rom_array:
  - DEPTH x 32 single-clock array.
  - One synchronous read port (re, raddr, rdata) and one write port.
  - Read-before-write.
  - No reset.
  - Keeps the storage inferable as block RAM.

Test Plan:
- Reset release: after rst falls, rd_ready_o is 0 in the first cycle and 1 after one edge. Outputs during reset are 0 / `ZeroWord.
- Program mem[0..3] = 0x00500093, 0x00100113, 0x002081B3, 0x0000006F. Issue pc 0,4,8,12 on consecutive cycles with LATENCY=1 → four consecutive inst_valid_o pulses with those words in order, err=0.
- LATENCY=3: a single request pc=0x4 at edge N → inst_valid_o only after edge N+2, data 0x00100113, pulse width 1.
- Error cases:
  - pc=0x6 (misaligned) → err=1, data 0x00000013.
  - pc=DEPTH*4=0x1000 → err=1, data 0x00000013.
- Flush, LATENCY=3: requests pc=0,4 then flush_i in the next cycle → no inst_valid_o pulses. rd_ready_o is 0 during the flush cycle. A new request pc=8 then returns 0x002081B3.
- Same-edge write mem[2]=0xDEADBEEF with read pc=8 → returns old 0x002081B3. A following read pc=8 returns 0xDEADBEEF.
- Reset mid-flight (LATENCY=2): assert rst one cycle after a request → no response pulse after release.
